// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared codes for the pipeline hazard controller: forward selects and
// multi-cycle wait FSM state encodings.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [0:0] {
    STATE_RUN     = 1'b0,
    STATE_MC_WAIT = 1'b1
  } state_t;

  // EX/MEM result is younger than MEM/WB, so it takes priority.
  function automatic logic [1:0] fwd_code(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register fields in,
// forward selects, enables and counters out.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
);

  logic [NSRC*REG_AW-1:0] id_src;
  logic                   id_is_branch;
  logic                   id_branch_taken;
  logic [NSRC*REG_AW-1:0] ex_src;
  logic [REG_AW-1:0]      ex_rd;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic [REG_AW-1:0]      mem_rd;
  logic                   mem_reg_write;
  logic                   mem_mem_read;
  logic [REG_AW-1:0]      wb_rd;
  logic                   wb_reg_write;
  logic                   ex_mc_start;
  logic                   ex_mc_done;

  logic [NSRC*2-1:0]      fwd_ex;
  logic [NSRC*2-1:0]      fwd_id;
  logic                   pc_write;
  logic                   if_id_write;
  logic                   id_ex_bubble;
  logic                   ex_hold;
  logic                   if_id_flush;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  modport master (
    output id_src, id_is_branch, id_branch_taken, ex_src,
    output ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, mem_mem_read,
    output wb_rd, wb_reg_write, ex_mc_start, ex_mc_done,
    input  fwd_ex, fwd_id, pc_write, if_id_write, id_ex_bubble,
    input  ex_hold, if_id_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src, id_is_branch, id_branch_taken, ex_src,
    input  ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, mem_mem_read,
    input  wb_rd, wb_reg_write, ex_mc_start, ex_mc_done,
    output fwd_ex, fwd_id, pc_write, if_id_write, id_ex_bubble,
    output ex_hold, if_id_flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Forward select for a single source operand: compares against the EX/MEM
// and MEM/WB destinations; r0 is hardwired and never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  // Priority compare, EX/MEM over MEM/WB.
  always_comb begin
    mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);
    sel     = fwd_code(mem_hit, wb_hit);
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Central hazard controller: operand forwarding for EX and ID, load-use and
// branch-in-ID stalls, multi-cycle EX wait, taken-branch flush and
// saturating stall/flush counters.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  hazard_forward_ctrl_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic              mc_stall;
  logic              ex_hit;
  logic              ex_ld_hit;
  logic              mem_ld_hit;
  logic              lu;
  logic              br;
  logic              stall_h;
  logic              any_stall;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic [NSRC*2-1:0] fwd_ex_w;
  logic [NSRC*2-1:0] fwd_id_w;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_ex (
      .src           (bus.ex_src[i*REG_AW +: REG_AW]),
      .mem_rd        (bus.mem_rd),
      .mem_reg_write (bus.mem_reg_write),
      .wb_rd         (bus.wb_rd),
      .wb_reg_write  (bus.wb_reg_write),
      .sel           (fwd_ex_w[i*2 +: 2])
    );
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_id (
      .src           (bus.id_src[i*REG_AW +: REG_AW]),
      .mem_rd        (bus.mem_rd),
      .mem_reg_write (bus.mem_reg_write),
      .wb_rd         (bus.wb_rd),
      .wb_reg_write  (bus.wb_reg_write),
      .sel           (fwd_id_w[i*2 +: 2])
    );
  end

  // Match the ID sources against the EX and MEM destinations (r0 excluded).
  always_comb begin
    ex_hit     = 1'b0;
    ex_ld_hit  = 1'b0;
    mem_ld_hit = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if ((bus.ex_rd != '0) && (bus.id_src[i*REG_AW +: REG_AW] == bus.ex_rd)) begin
        ex_hit = 1'b1;
      end
      if ((bus.mem_rd != '0) && (bus.id_src[i*REG_AW +: REG_AW] == bus.mem_rd)) begin
        mem_ld_hit = 1'b1;
      end
    end
    ex_ld_hit  = ex_hit & bus.ex_mem_read;
    mem_ld_hit = mem_ld_hit & bus.mem_mem_read;
  end

  // Hazard terms; the pipeline re-evaluates them every cycle while stalled.
  always_comb begin
    lu      = ex_ld_hit;
    br      = bus.id_is_branch & ((bus.ex_reg_write & ex_hit) | mem_ld_hit);
    stall_h = lu | br;
  end

  // Multi-cycle wait FSM: next state and the wait stall.
  always_comb begin
    state_nx = state;
    mc_stall = 1'b0;
    unique case (state)
      STATE_RUN: begin
        // start and done together means a single-cycle op: no wait.
        if (bus.ex_mc_start && !bus.ex_mc_done) state_nx = STATE_MC_WAIT;
      end
      STATE_MC_WAIT: begin
        // The done cycle itself releases the pipeline.
        mc_stall = !bus.ex_mc_done;
        if (bus.ex_mc_done) state_nx = STATE_RUN;
      end
      default: state_nx = STATE_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= STATE_RUN;
    else       state <= state_nx;
  end

  // Pipeline enables, bubble, hold and flush.
  always_comb begin
    any_stall = stall_h | mc_stall;
    flush     = bus.id_is_branch & bus.id_branch_taken & ~any_stall;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (any_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.fwd_ex       = fwd_ex_w;
  assign bus.fwd_id       = fwd_id_w;
  assign bus.pc_write     = ~any_stall;
  assign bus.if_id_write  = ~any_stall;
  assign bus.ex_hold      = mc_stall;
  assign bus.id_ex_bubble = stall_h & ~mc_stall;
  assign bus.if_id_flush  = flush;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
